// File: rtl/register_universal_pkg.sv
// rtl/register_universal_pkg.sv - mode encodings shared by the universal register and its bit cell
package register_universal_pkg;

  typedef logic [1:0] modo_t;

  localparam modo_t MODO_RETENER = 2'b00;
  localparam modo_t MODO_DER     = 2'b01;
  localparam modo_t MODO_IZQ     = 2'b10;
  localparam modo_t MODO_CARGA   = 2'b11;

  // True for the two modes that move data and advance the shift counter.
  function automatic logic es_desplazamiento(input modo_t m);
    return (m == MODO_DER) || (m == MODO_IZQ);
  endfunction

endpackage

// File: rtl/register_universal_cell.sv
// rtl/register_universal_cell.sv - one bit of the universal register: DFF behind a 4:1 mode mux
module register_universal_cell
  import register_universal_pkg::*;
(
  input  logic  clk,
  input  logic  reset_sync,
  input  logic  habilitar,
  input  modo_t modo,
  input  logic  d_izq,
  input  logic  d_der,
  input  logic  d_carga,
  output logic  q
);

  logic q_q;
  logic q_d;

  // d_izq is the left (higher) neighbour, taken on shift right; d_der the reverse.
  always_comb begin
    q_d = q_q;
    if (habilitar) begin
      case (modo)
        MODO_DER:   q_d = d_izq;
        MODO_IZQ:   q_d = d_der;
        MODO_CARGA: q_d = d_carga;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register_universal_nbits.sv
// rtl/register_universal_nbits.sv - W-bit universal shift/load register; REGISTER_UNIVERSAL_ROTATE_EN adds rotar
module register_universal_nbits
  import register_universal_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset_sync,
  input  logic          habilitar,
  input  logic [1:0]    modo,
  input  logic [W-1:0]  In,
  input  logic          serial_izq,
  input  logic          serial_der,
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
  input  logic          rotar,
`endif
  output logic [W-1:0]  An,
  output logic          sal_der,
  output logic          sal_izq,
  output logic [CW-1:0] cuenta,
  output logic          vacio
);

  localparam logic [CW-1:0] CUENTA_MAX = CW'(W);

  logic [W-1:0]  an_w;
  logic          entra_izq;
  logic          entra_der;
  logic [CW-1:0] cuenta_q, cuenta_d;
  logic          vacio_q, vacio_d;

`ifdef REGISTER_UNIVERSAL_ROTATE_EN
  // Rotation closes the ring: the bit leaving one end re-enters at the other.
  assign entra_izq = rotar ? an_w[0]   : serial_izq;
  assign entra_der = rotar ? an_w[W-1] : serial_der;
`else
  assign entra_izq = serial_izq;
  assign entra_der = serial_der;
`endif

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic d_izq_w;
    logic d_der_w;

    if (i == W - 1) begin : g_msb
      assign d_izq_w = entra_izq;
    end else begin : g_mid_izq
      assign d_izq_w = an_w[i+1];
    end

    if (i == 0) begin : g_lsb
      assign d_der_w = entra_der;
    end else begin : g_mid_der
      assign d_der_w = an_w[i-1];
    end

    register_universal_cell u_cell (
      .clk        (clk),
      .reset_sync (reset_sync),
      .habilitar  (habilitar),
      .modo       (modo_t'(modo)),
      .d_izq      (d_izq_w),
      .d_der      (d_der_w),
      .d_carga    (In[i]),
      .q          (an_w[i])
    );
  end

  // vacio is derived from cuenta_d so both registers always agree after each edge.
  always_comb begin
    cuenta_d = cuenta_q;
    if (habilitar) begin
      if (modo_t'(modo) == MODO_CARGA) begin
        cuenta_d = '0;
      end else if (es_desplazamiento(modo_t'(modo)) && (cuenta_q != CUENTA_MAX)) begin
        cuenta_d = cuenta_q + CW'(1);
      end
    end
    vacio_d = (cuenta_d == CUENTA_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      cuenta_q <= '0;
      vacio_q  <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      vacio_q  <= vacio_d;
    end
  end

  assign An      = an_w;
  assign sal_der = an_w[0];
  assign sal_izq = an_w[W-1];
  assign cuenta  = cuenta_q;
  assign vacio   = vacio_q;

endmodule

// File: tb/tb_register_universal_nbits.sv
// tb/tb_register_universal_nbits.sv - scoreboard bench for W=4 and W=8 universal registers
module tb_register_universal_nbits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, hab4, si4, sd4;
  logic [1:0] m4;
  logic [3:0] in4, an4;
  logic [2:0] c4;
  logic       sd_o4, si_o4, v4;

  logic       rst8, hab8, si8, sd8;
  logic [1:0] m8;
  logic [7:0] in8, an8;
  logic [3:0] c8;
  logic       sd_o8, si_o8, v8;
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
  logic       rot4, rot8;
`endif

  register_universal_nbits #(.W(4)) u_dut4 (
    .clk(clk), .reset_sync(rst4), .habilitar(hab4), .modo(m4), .In(in4),
    .serial_izq(si4), .serial_der(sd4),
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
    .rotar(rot4),
`endif
    .An(an4), .sal_der(sd_o4), .sal_izq(si_o4), .cuenta(c4), .vacio(v4)
  );

  register_universal_nbits #(.W(8)) u_dut8 (
    .clk(clk), .reset_sync(rst8), .habilitar(hab8), .modo(m8), .In(in8),
    .serial_izq(si8), .serial_der(sd8),
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
    .rotar(rot8),
`endif
    .An(an8), .sal_der(sd_o8), .sal_izq(si_o8), .cuenta(c8), .vacio(v8)
  );

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] an;
    logic [3:0] cnt;
    logic       vac;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: the DUT has no valid strobe, so every pushed entry is checked on the next falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.dut == 4) begin
        chk(e.name, "An",      32'(an4),   32'(e.an[3:0]));
        chk(e.name, "cuenta",  32'(c4),    32'(e.cnt[2:0]));
        chk(e.name, "vacio",   32'(v4),    32'(e.vac));
        chk(e.name, "sal_der", 32'(sd_o4), 32'(e.an[0]));
        chk(e.name, "sal_izq", 32'(si_o4), 32'(e.an[3]));
      end else begin
        chk(e.name, "An",      32'(an8),   32'(e.an));
        chk(e.name, "cuenta",  32'(c8),    32'(e.cnt));
        chk(e.name, "vacio",   32'(v8),    32'(e.vac));
        chk(e.name, "sal_der", 32'(sd_o8), 32'(e.an[0]));
        chk(e.name, "sal_izq", 32'(si_o8), 32'(e.an[7]));
      end
    end
  end

  task automatic step4(input string nm, input logic r, input logic h, input logic [1:0] m,
                       input logic [3:0] d, input logic si, input logic sd,
                       input logic [3:0] ea, input logic [2:0] ec, input logic ev);
    exp_t e;
    rst4 = r; hab4 = h; m4 = m; in4 = d; si4 = si; sd4 = sd;
    @(posedge clk);
    #1;
    e.name = nm; e.dut = 4; e.an = {4'h0, ea}; e.cnt = {1'b0, ec}; e.vac = ev;
    sb.push_back(e);
  endtask

  task automatic step8(input string nm, input logic r, input logic h, input logic [1:0] m,
                       input logic [7:0] d, input logic sd, input logic rot,
                       input logic [7:0] ea, input logic [3:0] ec, input logic ev);
    exp_t e;
    rst8 = r; hab8 = h; m8 = m; in8 = d; si8 = 1'b0; sd8 = sd;
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
    rot8 = rot;
`else
    if (rot) $display("note: rotar requested but not built in");
`endif
    @(posedge clk);
    #1;
    e.name = nm; e.dut = 8; e.an = ea; e.cnt = ec; e.vac = ev;
    sb.push_back(e);
  endtask

  logic [7:0] exp_rot [8];

  initial begin
    rst4 = 1'b1; hab4 = 1'b0; m4 = 2'b00; in4 = '0; si4 = 1'b0; sd4 = 1'b0;
    rst8 = 1'b1; hab8 = 1'b0; m8 = 2'b00; in8 = '0; si8 = 1'b0; sd8 = 1'b0;
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
    rot4 = 1'b0; rot8 = 1'b0;
    exp_rot = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
`else
    exp_rot = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
`endif

    //     name          rst  hab  modo   In     si  sd   An      cnt   vac
    step4("reset",       1,   1,   2'b01, 4'h0,  1,  1,   4'b0000, 3'd0, 0);
    step4("load1011",    0,   1,   2'b11, 4'hB,  0,  0,   4'b1011, 3'd0, 0);
    step4("shr0",        0,   1,   2'b01, 4'h0,  0,  0,   4'b0101, 3'd1, 0);
    step4("shr1",        0,   1,   2'b01, 4'h0,  1,  0,   4'b1010, 3'd2, 0);
    step4("shr2",        0,   1,   2'b01, 4'h0,  1,  0,   4'b1101, 3'd3, 0);
    step4("shr3",        0,   1,   2'b01, 4'h0,  0,  0,   4'b0110, 3'd4, 1);
    step4("sat_shl0",    0,   1,   2'b10, 4'h0,  0,  1,   4'b1101, 3'd4, 1);
    step4("sat_shl1",    0,   1,   2'b10, 4'h0,  0,  1,   4'b1011, 3'd4, 1);
    step4("dis_load",    0,   0,   2'b11, 4'hF,  0,  0,   4'b1011, 3'd4, 1);
    step4("dis_shift",   0,   0,   2'b01, 4'h0,  1,  0,   4'b1011, 3'd4, 1);
    step4("load0011",    0,   1,   2'b11, 4'h3,  0,  0,   4'b0011, 3'd0, 0);
    step4("mix_r",       0,   1,   2'b01, 4'h0,  1,  0,   4'b1001, 3'd1, 0);
    step4("mix_l",       0,   1,   2'b10, 4'h0,  0,  0,   4'b0010, 3'd2, 0);
    step4("load_mid",    0,   1,   2'b11, 4'h6,  0,  0,   4'b0110, 3'd0, 0);
    step4("hold",        0,   1,   2'b00, 4'hF,  1,  1,   4'b0110, 3'd0, 0);
    step4("rst_dis",     1,   0,   2'b11, 4'hF,  0,  0,   4'b0000, 3'd0, 0);
    step4("load1111",    0,   1,   2'b11, 4'hF,  0,  0,   4'b1111, 3'd0, 0);
    step4("shl_a",       0,   1,   2'b10, 4'h0,  0,  0,   4'b1110, 3'd1, 0);
    step4("rst_load",    1,   1,   2'b11, 4'hA,  0,  0,   4'b0000, 3'd0, 0);
    step4("post_rst",    0,   1,   2'b00, 4'h0,  0,  0,   4'b0000, 3'd0, 0);
    hab4 = 1'b0;

    step8("w8_reset",    1, 1, 2'b11, 8'hFF, 0, 0, 8'h00, 4'd0, 0);
    step8("w8_load81",   0, 1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef REGISTER_UNIVERSAL_ROTATE_EN
      step8($sformatf("w8_rot%0d", i), 0, 1, 2'b10, 8'h00, 0, 1, exp_rot[i], 4'(i + 1), i == 7);
`else
      step8($sformatf("w8_shl%0d", i), 0, 1, 2'b10, 8'h00, 0, 0, exp_rot[i], 4'(i + 1), i == 7);
`endif
    end
    step8("w8_sat",      0, 1, 2'b01, 8'h00, 0, 0, {1'b0, exp_rot[7][7:1]}, 4'd8, 1);
    step8("w8_rst_mid",  1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 4'd0, 0);
    hab8 = 1'b0;
    rst8 = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("drain", "queue", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
